// File: rtl/qos_fifo_pkg.sv
// Shared definitions for the QoS queue pointer controllers.
package qos_fifo_pkg;

  // Default address width: 256-word queue.
  localparam int ADDR_W_DEF = 8;

  // Widest pointer the compare helpers accept (address bits plus wrap bit).
  localparam int PTR_MAX_W = 17;

  // Callers zero-extend their ADDR_W+1 bit pointers to PTR_MAX_W and pass
  // their address width. Full means the two pointers differ in the wrap bit
  // only. Because the upper bits are zero, that is an XOR equal to 1 << aw.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] a,
                                    input logic [PTR_MAX_W-1:0] b,
                                    input logic [4:0]           aw);
    return ((a ^ b) == (PTR_MAX_W'(1) << aw));
  endfunction

  // Empty means the pointers are identical, including the wrap bit.
  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] a,
                                     input logic [PTR_MAX_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/qos_fifo_ptr_ctrl_ptr_ctr.sv
// Pointer counter with a wrap bit. Load has priority over increment.
module qos_ptr_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, increment or hold. Overflow wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (ld)       cnt_d = ld_val;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/qos_fifo_ptr_ctrl.sv
// Pointer and flag controller for one QoS queue buffer. It keeps a
// speculative write pointer, a committed write pointer and a read pointer.
// Packets are published to the reader on commit, or rewound on drop.
module qos_fifo_ptr_ctrl
  import qos_fifo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AFULL_TH = 2**ADDR_W - 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WP_en,
  input  logic            RP_en,
  input  logic            pkt_commit,
  input  logic            pkt_drop,
  output logic [ADDR_W-1:0] WP,
  output logic [ADDR_W-1:0] RP,
  output logic            FIFO_EMPTY,
  output logic            FIFO_FULL,
  output logic            almost_full,
  output logic [ADDR_W:0] count,
  output logic            wr_rej,
  output logic            rd_rej
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wp, rp;
  logic [PW-1:0] cwp_q, cwp_d;
  logic [PW-1:0] wp_inc;
  logic [PW-1:0] spec_occ;
  logic          wr_acc, rd_acc;
  logic          wr_rej_q, wr_rej_d;
  logic          rd_rej_q, rd_rej_d;
  logic          full, empty;

  // Flags decode registered pointers only. No input reaches an output.
  always_comb begin
    full     = ptr_full(PTR_MAX_W'(wp), PTR_MAX_W'(rp), 5'(ADDR_W));
    empty    = ptr_empty(PTR_MAX_W'(cwp_q), PTR_MAX_W'(rp));
    spec_occ = wp - rp;
  end

  // Accept and refuse decisions. A drop discards any same-cycle write
  // without flagging it as refused. Reads see only committed data as of
  // this cycle, so there is no same-cycle bypass from commit to read.
  always_comb begin
    wr_acc   = WP_en && !full && !pkt_drop;
    wr_rej_d = WP_en &&  full && !pkt_drop;
    rd_acc   = RP_en && !empty;
    rd_rej_d = RP_en &&  empty;
    wp_inc   = wp + PW'(wr_acc);
  end

  // Committed pointer. Drop wins over commit. A commit includes a word
  // accepted in the same cycle.
  always_comb begin
    cwp_d = cwp_q;
    if (pkt_drop)        cwp_d = cwp_q;
    else if (pkt_commit) cwp_d = wp_inc;
  end

  // Speculative write pointer. A drop rewinds it to the committed pointer.
  qos_ptr_ctr #(.W(PW)) u_wp_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (wr_acc),
    .ld     (pkt_drop),
    .ld_val (cwp_q),
    .cnt    (wp)
  );

  // Read pointer. It never passes cwp because reads require !empty.
  qos_ptr_ctr #(.W(PW)) u_rp_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (rd_acc),
    .ld     (1'b0),
    .ld_val ('0),
    .cnt    (rp)
  );

  // Committed pointer and the one-cycle refuse pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cwp_q    <= '0;
      wr_rej_q <= 1'b0;
      rd_rej_q <= 1'b0;
    end else begin
      cwp_q    <= cwp_d;
      wr_rej_q <= wr_rej_d;
      rd_rej_q <= rd_rej_d;
    end
  end

  assign WP          = wp[ADDR_W-1:0];
  assign RP          = rp[ADDR_W-1:0];
  assign FIFO_EMPTY  = empty;
  assign FIFO_FULL   = full;
  assign almost_full = (spec_occ >= PW'(AFULL_TH));
  assign count       = cwp_q - rp;
  assign wr_rej      = wr_rej_q;
  assign rd_rej      = rd_rej_q;

endmodule

// File: tb/tb_qos_fifo_ptr_ctrl.sv
// Scoreboard bench for qos_fifo_ptr_ctrl at ADDR_W=3, AFULL_TH=6.
module tb_qos_fifo_ptr_ctrl;

  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic WP_en = 1'b0, RP_en = 1'b0, pkt_commit = 1'b0, pkt_drop = 1'b0;
  logic [AW-1:0] WP, RP;
  logic          FIFO_EMPTY, FIFO_FULL, almost_full;
  logic [AW:0]   count;
  logic          wr_rej, rd_rej;

  always #5 clk = ~clk;

  qos_fifo_ptr_ctrl #(.ADDR_W(AW), .AFULL_TH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .WP_en       (WP_en),
    .RP_en       (RP_en),
    .pkt_commit  (pkt_commit),
    .pkt_drop    (pkt_drop),
    .WP          (WP),
    .RP          (RP),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .FIFO_FULL   (FIFO_FULL),
    .almost_full (almost_full),
    .count       (count),
    .wr_rej      (wr_rej),
    .rd_rej      (rd_rej)
  );

  typedef struct {
    int wp; int rp; int empty; int full; int afull; int cnt; int wrej; int rrej;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  // Reference state: pointers modulo 16, data sequence bookkeeping.
  int mwp = 0, mcwp = 0, mrp = 0;
  int mem [8];
  int pend[$];
  int comm[$];
  int seq = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: each edge, compare the DUT outputs with the oldest expectation.
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("WP",          int'(WP),          e.wp);
      chk("RP",          int'(RP),          e.rp);
      chk("FIFO_EMPTY",  int'(FIFO_EMPTY),  e.empty);
      chk("FIFO_FULL",   int'(FIFO_FULL),   e.full);
      chk("almost_full", int'(almost_full), e.afull);
      chk("count",       int'(count),       e.cnt);
      chk("wr_rej",      int'(wr_rej),      e.wrej);
      chk("rd_rej",      int'(rd_rej),      e.rrej);
    end
  end

  // One cycle of stimulus. Drive the inputs, advance the occupancy model,
  // push the expected post-edge outputs, then wait for the edge.
  task automatic cyc(input bit we, input bit re, input bit com, input bit drp);
    exp_t e;
    int   occ, wacc, racc;
    bit   full, empty;
    WP_en = we; RP_en = re; pkt_commit = com; pkt_drop = drp;
    occ   = (mwp - mrp) & 15;
    full  = (occ == 8);
    empty = (mcwp == mrp);
    wacc  = (we && !full && !drp) ? 1 : 0;
    racc  = (re && !empty) ? 1 : 0;
    e.wrej = (we && full && !drp) ? 1 : 0;
    e.rrej = (re && empty) ? 1 : 0;
    if (wacc != 0) begin
      mem[WP] = seq;
      pend.push_back(seq);
      seq++;
    end
    if (racc != 0) begin
      if (comm.size() != 0) chk("rd_data", mem[RP], comm.pop_front());
      else begin
        n_vec++; n_err++;
        $display("FAIL rd_data: read accepted with no committed word at %0t", $time);
      end
    end
    if (drp) begin
      pend.delete();
      mwp = mcwp;
    end else begin
      mwp = (mwp + wacc) & 15;
      if (com) begin
        while (pend.size() != 0) comm.push_back(pend.pop_front());
        mcwp = mwp;
      end
    end
    mrp     = (mrp + racc) & 15;
    e.wp    = mwp & 7;
    e.rp    = mrp & 7;
    e.empty = (mcwp == mrp) ? 1 : 0;
    e.full  = (((mwp - mrp) & 15) == 8) ? 1 : 0;
    e.afull = (((mwp - mrp) & 15) >= 6) ? 1 : 0;
    e.cnt   = (mcwp - mrp) & 15;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_WP"},    int'(WP),          0);
    chk({tag, "_RP"},    int'(RP),          0);
    chk({tag, "_EMPTY"}, int'(FIFO_EMPTY),  1);
    chk({tag, "_FULL"},  int'(FIFO_FULL),   0);
    chk({tag, "_AFULL"}, int'(almost_full), 0);
    chk({tag, "_COUNT"}, int'(count),       0);
    chk({tag, "_WREJ"},  int'(wr_rej),      0);
    chk({tag, "_RREJ"},  int'(rd_rej),      0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Reads while empty pulse rd_rej and hold RP.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Three words with commit on the third, then read them back.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 0);

    // Empty queue with commit and read together: the read is refused.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);

    // Fill with no commit, then a refused ninth write.
    repeat (8) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Full and nothing committed: write and read both refused, commit lands.
    cyc(1, 1, 1, 0);
    // Full: the read is accepted and the write is refused.
    cyc(1, 1, 0, 0);
    repeat (7) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // Drop while writing the sixth word, then drop wins over commit.
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);

    // Stream 20 words in 4-word packets with concurrent reads, then drain.
    for (int i = 0; i < 20; i++) cyc(1, 1, (i % 4) == 3, 0);
    repeat (8) cyc(0, 1, 0, 0);

    // Mid-packet asynchronous reset with three words committed.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    WP_en = 1'b0; RP_en = 1'b0; pkt_commit = 1'b0; pkt_drop = 1'b0;
    chk("pre_rst_count", int'(count), 3);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    mwp = 0; mcwp = 0; mrp = 0;
    pend.delete();
    comm.delete();
    @(posedge clk);
    #2 rst = 1'b0;

    // Normal operation after reset.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_drain: %0d expectations left unchecked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
